// File: rtl/gfsk_vco.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gfsk_vco : phase-accumulating VCO with a loadable cos table -> I/Q samples  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gfsk_vco #(
   parameter int GAUSS_FILTER_BIT_WIDTH = 16,
   parameter int VCO_BIT_WIDTH          = 16,
   parameter int SIN_COS_ADDR_BIT_WIDTH = 11,
   parameter int IQ_BIT_WIDTH           = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [SIN_COS_ADDR_BIT_WIDTH-1:0] cos_table_write_address,
   input  logic [IQ_BIT_WIDTH-1:0]           cos_table_write_data,
   input  logic                              cos_table_write_enable,
   input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] bit_upsample_gauss_filter,
   input  logic                              bit_upsample_gauss_filter_valid,
   input  logic                              bit_upsample_gauss_filter_valid_last,
   output logic [IQ_BIT_WIDTH-1:0]           cos_out,
   output logic [IQ_BIT_WIDTH-1:0]           sin_out,
   output logic                              sin_cos_out_valid,
   output logic                              sin_cos_out_valid_last
);

   localparam int                              DEPTH   = 1 << SIN_COS_ADDR_BIT_WIDTH;
   localparam logic [SIN_COS_ADDR_BIT_WIDTH-1:0] QUARTER = SIN_COS_ADDR_BIT_WIDTH'(DEPTH / 4);

   logic [IQ_BIT_WIDTH-1:0]           cos_table [DEPTH];
   logic [VCO_BIT_WIDTH-1:0]          phase;
   logic [VCO_BIT_WIDTH-1:0]          freq_ext;
   logic [VCO_BIT_WIDTH-1:0]          sum;
   logic [SIN_COS_ADDR_BIT_WIDTH-1:0] addr;
   logic [SIN_COS_ADDR_BIT_WIDTH-1:0] sin_addr;
   logic                              stage1_valid;
   logic                              stage1_last;

   assign freq_ext = VCO_BIT_WIDTH'($signed(bit_upsample_gauss_filter));
   assign sum      = phase + freq_ext;
   // sin lags cos by a quarter period of the table
   assign sin_addr = addr - QUARTER;

   // Table is software-loaded and survives reset; same-entry read sees old data.
   always_ff @(posedge clk) begin
      if (cos_table_write_enable)
         cos_table[cos_table_write_address] <= cos_table_write_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= '0;
         addr         <= '0;
         stage1_valid <= 1'b0;
         stage1_last  <= 1'b0;
      end else begin
         stage1_valid <= bit_upsample_gauss_filter_valid;
         stage1_last  <= bit_upsample_gauss_filter_valid & bit_upsample_gauss_filter_valid_last;
         if (bit_upsample_gauss_filter_valid) begin
            addr  <= sum[VCO_BIT_WIDTH-1 -: SIN_COS_ADDR_BIT_WIDTH];
            phase <= bit_upsample_gauss_filter_valid_last ? '0 : sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cos_out                <= '0;
         sin_out                <= '0;
         sin_cos_out_valid      <= 1'b0;
         sin_cos_out_valid_last <= 1'b0;
      end else begin
         sin_cos_out_valid      <= stage1_valid;
         sin_cos_out_valid_last <= stage1_last;
         if (stage1_valid) begin
            cos_out <= cos_table[addr];
            sin_out <= cos_table[sin_addr];
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/gfsk_vco.md
GFSK_VCO -- requirements
Module: gfsk_vco

Interface
REQ-001 SHALL have parameter GAUSS_FILTER_BIT_WIDTH, default 16: width of the signed frequency input sample.
REQ-002 SHALL have parameter VCO_BIT_WIDTH, default 16: width of the phase accumulator; must be >= GAUSS_FILTER_BIT_WIDTH.
REQ-003 SHALL have parameter SIN_COS_ADDR_BIT_WIDTH, default 11: cos table address width; the table has 2^SIN_COS_ADDR_BIT_WIDTH entries.
REQ-004 SHALL have parameter IQ_BIT_WIDTH, default 8: width of the signed cos table entries and of the I/Q outputs.
REQ-005 SHALL have port clk, input, 1: the single clock; every register is rising-edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port cos_table_write_address, input, SIN_COS_ADDR_BIT_WIDTH: the table entry to write.
REQ-008 SHALL have port cos_table_write_data, input, IQ_BIT_WIDTH: the signed table value to write.
REQ-009 SHALL have port cos_table_write_enable, input, 1: writes the entry on this cycle.
REQ-010 SHALL have port bit_upsample_gauss_filter, input, GAUSS_FILTER_BIT_WIDTH: the signed frequency sample from the Gaussian filter.
REQ-011 SHALL have port bit_upsample_gauss_filter_valid, input, 1: the input sample is valid on this cycle.
REQ-012 SHALL have port bit_upsample_gauss_filter_valid_last, input, 1: marks the final sample of a packet; it is qualified by valid.
REQ-013 SHALL have port cos_out, output, IQ_BIT_WIDTH: the signed I sample.
REQ-014 SHALL have port sin_out, output, IQ_BIT_WIDTH: the signed Q sample.
REQ-015 SHALL have ports sin_cos_out_valid and sin_cos_out_valid_last, output, 1 each: the output strobe and the packet-last flag.

Function
REQ-016 SHALL hold one table of 2^SIN_COS_ADDR_BIT_WIDTH signed entries; an entry is written on the clk edge when cos_table_write_enable=1.
REQ-017 SHALL leave table contents unchanged by reset; the table is loaded by software before traffic.
REQ-018 SHALL hold a VCO_BIT_WIDTH phase register, called phase.
REQ-019 SHALL compute sum = (phase + sign-extended input) modulo 2^VCO_BIT_WIDTH; wrap-around is silent, with no saturation.
REQ-020 SHALL form the stage-1 address register addr = sum[VCO_BIT_WIDTH-1 : VCO_BIT_WIDTH-SIN_COS_ADDR_BIT_WIDTH] on a valid cycle, using the top bits only with no rounding.
REQ-021 SHALL update phase on a valid cycle: phase <= sum when valid_last=0, and phase <= 0 when valid_last=1, so the next packet starts at phase 0.
REQ-022 SHALL leave phase and addr unchanged on a non-valid cycle.
REQ-023 SHALL register in stage 2: cos_out <= table[addr], and sin_out <= table[(addr - 2^(SIN_COS_ADDR_BIT_WIDTH-2)) mod 2^SIN_COS_ADDR_BIT_WIDTH], i.e. the quarter-period offset.
REQ-024 SHALL give a fixed latency of 2 cycles: input valid on edge N gives sin_cos_out_valid=1 after edge N+2, for exactly one cycle per input.
REQ-025 SHALL delay valid_last by the same 2 cycles and assert it only together with sin_cos_out_valid.
REQ-026 SHALL hold cos_out and sin_out at their last values while sin_cos_out_valid=0.
REQ-027 SHALL accept an input on every cycle (back-to-back, 16 MHz), at any duty cycle, with no backpressure.
REQ-028 SHALL resolve a table write and a read of the same entry on the same cycle as read-old-data; the write takes effect for the next read.
REQ-029 SHALL treat valid_last=1 with valid=0 as no effect.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear phase, addr, cos_out, sin_out, sin_cos_out_valid, sin_cos_out_valid_last and the internal valid/last pipeline to 0.
REQ-031 SHALL discard any sample in flight when reset is asserted mid-packet; no output strobe appears after rst_n rises until a new input valid arrives.
REQ-032 SHALL sample rst_n deassertion synchronously to clk by the surrounding logic; the block takes no action on the release edge.

Verification
REQ-033 SHALL cover: load table[i] = i mod 256 (as signed 8-bit), then input = 32 with valid for 4 cycles -> cos_out = 1,2,3,4 and sin_out = table[1-512 mod 2048] = table[1537] (=1), 2, 3, 4, each valid 2 cycles after its input.
REQ-034 SHALL cover: input = -32 from phase 0 -> addr 2047, cos_out = table[2047] = -1 (0xFF); this proves wrap-around.
REQ-035 SHALL cover: 3 samples of 32 with the last flag on the third, then 1 sample of 32 -> outputs cos 1,2,3 with last on 3, then cos 1, since phase restarts at 0.
REQ-036 SHALL cover: valid pulses every other cycle (8 MHz pattern) -> one output per input and identical values to the back-to-back run.
REQ-037 SHALL cover: rst_n pulled low mid-packet, with 1 sample in stage 1 and 1 in stage 2 -> all outputs read 0 immediately and no stray valid strobe after release.
REQ-038 SHALL cover: a write to table[5]=77 on the same cycle addr=5 is read -> the old value is output, and the next read of entry 5 returns 77.
